// File: rtl/lb_reg_bank.sv
// ----------------------------------------------------------------------------
// lb_reg_bank
// Local-bus register bank: eight read/write config registers, a write-1
// pulse register, write/read transaction counters, eight read-only status
// words and a constant ID word, all behind one 8-bit base address.
//
// Parameters
//   read_pipe_len  cycles from read strobe to valid lb_rdata (>= 1)
//   base           value matched against lb_addr[23:16]
//   id_word        constant returned at offset 0x1F
//
// Ports
//   clk        single rising-edge clock
//   rst        asynchronous active-high reset
//   lb_addr    24-bit bus address, held stable between strobes
//   lb_strobe  one-cycle transaction marker
//   lb_rd      1 = read, 0 = write (qualified by lb_strobe)
//   lb_wdata   write data, valid with lb_strobe
//   lb_rdata   read data; holds the last read result
//   cfg_regs   eight 32-bit config registers, reg n at [32n+31:32n]
//   pulse_out  one-cycle pulse of the data written to offset 0x08
//   status_in  eight 32-bit read-only status words, same packing
//
// Handshake: there is no back-pressure. A transaction is a single-cycle
// lb_strobe; writes take effect on that edge, and read data appears on
// lb_rdata exactly read_pipe_len cycles after the strobe and is held there.
// ----------------------------------------------------------------------------
module lb_reg_bank #(
    parameter int          read_pipe_len = 1,
    parameter logic [7:0]  base          = 8'h00,
    parameter logic [31:0] id_word       = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [23:0]  lb_addr,
    input  logic         lb_strobe,
    input  logic         lb_rd,
    input  logic [31:0]  lb_wdata,
    output logic [31:0]  lb_rdata,
    output logic [255:0] cfg_regs,
    output logic [31:0]  pulse_out,
    input  logic [255:0] status_in
);

    logic [31:0] r_cfg [8];
    logic [15:0] r_wr_cnt;
    logic [15:0] r_rd_cnt;
    logic [31:0] r_pulse;
    logic [31:0] r_rdata;

    logic        w_hit;
    logic [4:0]  w_off;
    logic        w_wr;
    logic        w_rd;
    logic [31:0] w_rd_val;
    logic        w_fin_vld;
    logic [31:0] w_fin_data;

    // A hit needs the base byte to match and the unused middle bits to be 0.
    assign w_hit = (lb_addr[23:16] == base) && (lb_addr[15:5] == 11'd0);
    assign w_off = lb_addr[4:0];
    assign w_wr  = lb_strobe & ~lb_rd & w_hit;
    // Misses still count as reads: they must return 0 through the pipeline.
    assign w_rd  = lb_strobe & lb_rd;

    // Read lookup against the state as it stands on the strobe cycle.
    always_comb begin
        w_rd_val = 32'h0;
        if (w_hit) begin
            if (w_off[4:3] == 2'b00) begin
                w_rd_val = r_cfg[w_off[2:0]];
            end else if (w_off == 5'h09) begin
                w_rd_val = {16'h0, r_wr_cnt};
            end else if (w_off == 5'h0A) begin
                w_rd_val = {16'h0, r_rd_cnt};
            end else if (w_off[4:3] == 2'b10) begin
                w_rd_val = status_in[32*w_off[2:0] +: 32];
            end else if (w_off == 5'h1F) begin
                w_rd_val = id_word;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_cfg[i] <= 32'h0;
            end
            r_wr_cnt <= 16'h0;
            r_rd_cnt <= 16'h0;
            r_pulse  <= 32'h0;
        end else begin
            if (w_wr && (w_off[4:3] == 2'b00)) begin
                r_cfg[w_off[2:0]] <= lb_wdata;
            end
            // Counter counts every decoded write, wrapping naturally at 16 bits.
            if (w_wr) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
            // The 0x0A lookup above sees the pre-increment value.
            if (w_rd && w_hit) begin
                r_rd_cnt <= r_rd_cnt + 16'd1;
            end
            r_pulse <= (w_wr && (w_off == 5'h08)) ? lb_wdata : 32'h0;
        end
    end

    // The final holding register (r_rdata) is the last of read_pipe_len
    // stages; any extra stages sit in front of it as a valid-tagged shift.
    generate
        if (read_pipe_len <= 1) begin : g_direct
            assign w_fin_vld  = w_rd;
            assign w_fin_data = w_rd_val;
        end else begin : g_pipe
            localparam int PD = read_pipe_len - 1;
            logic [31:0] r_pd [PD];
            logic        r_pv [PD];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < PD; i++) begin
                        r_pd[i] <= 32'h0;
                        r_pv[i] <= 1'b0;
                    end
                end else begin
                    r_pd[0] <= w_rd_val;
                    r_pv[0] <= w_rd;
                    for (int i = 1; i < PD; i++) begin
                        r_pd[i] <= r_pd[i-1];
                        r_pv[i] <= r_pv[i-1];
                    end
                end
            end

            assign w_fin_vld  = r_pv[PD-1];
            assign w_fin_data = r_pd[PD-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'h0;
        end else if (w_fin_vld) begin
            r_rdata <= w_fin_data;
        end
    end

    assign lb_rdata  = r_rdata;
    assign pulse_out = r_pulse;

    generate
        for (genvar g = 0; g < 8; g++) begin : g_cfg_pack
            assign cfg_regs[32*g +: 32] = r_cfg[g];
        end
    endgenerate

endmodule
